// File: rtl/id_ex_imm_stage_pkg.sv
// Shared CPU constants: immediate-format encodings, zero-register number and
// the byte shift that turns an instruction-word offset into a byte offset.
package id_ex_imm_stage_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_D    = 3'd1,
        IMM_I    = 3'd2,
        IMM_CB   = 3'd3,
        IMM_B    = 3'd4,
        IMM_IM   = 3'd5
    } imm_sel_e;

    localparam logic [4:0] XZR         = 5'd31;
    localparam int         INSTR_SHIFT = 2;

    // Encodings above IMM_IM are reserved.
    function automatic logic sel_reserved(input logic [2:0] sel);
        return sel > IMM_IM;
    endfunction

endpackage

// File: rtl/id_ex_imm_stage_imm_select.sv
// Immediate selection and branch-target adder for the ID/EX stage.
// Purely combinational; the top registers its results.
module imm_select
    import id_ex_imm_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [2:0]   imm_sel,
    input  logic [W-1:0] Imm9,
    input  logic [W-1:0] Imm12,
    input  logic [W-1:0] Imm16,
    input  logic [W-1:0] Imm19,
    input  logic [W-1:0] Imm26,
    input  logic [1:0]   mov_hw,
    input  logic [W-1:0] pc_in,
    output logic [W-1:0] imm_next,
    output logic [W-1:0] tgt_next,
    output logic         illegal_sel
);

    logic [W-1:0] cb_off;
    logic [W-1:0] b_off;
    logic [W-1:0] im_val;
    logic         unused_imm16_hi;

    // Only the low halfword of the MOV immediate is meaningful.
    assign unused_imm16_hi = ^Imm16[W-1:16];

    assign cb_off = Imm19 << INSTR_SHIFT;
    assign b_off  = Imm26 << INSTR_SHIFT;
    // Logical shift by 16*hw; bits past W-1 fall off.
    assign im_val = W'(Imm16[15:0]) << {mov_hw, 4'b0000};

    always_comb begin
        imm_next = '0;
        tgt_next = pc_in + W'(4);
        case (imm_sel)
            IMM_D:   imm_next = Imm9;
            IMM_I:   imm_next = Imm12;
            IMM_CB: begin
                imm_next = cb_off;
                tgt_next = pc_in + cb_off;
            end
            IMM_B: begin
                imm_next = b_off;
                tgt_next = pc_in + b_off;
            end
            IMM_IM:  imm_next = im_val;
            default: imm_next = '0;
        endcase
    end

    assign illegal_sel = sel_reserved(imm_sel);

endmodule

// File: rtl/id_ex_imm_stage.sv
// ID/EX pipeline register for immediates and branch targets.
// Priority: reset > flush > stall > capture (empty slot loads a bubble).
module id_ex_imm_stage
    import id_ex_imm_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [2:0]   imm_sel,
    input  logic [W-1:0] Imm9,
    input  logic [W-1:0] Imm12,
    input  logic [W-1:0] Imm16,
    input  logic [W-1:0] Imm19,
    input  logic [W-1:0] Imm26,
    input  logic [1:0]   mov_hw,
    input  logic [W-1:0] pc_in,
    input  logic [4:0]   rd_in,
    output logic         out_valid,
    output logic [W-1:0] imm_out,
    output logic [W-1:0] br_target,
    output logic [4:0]   rd_out,
    output logic         illegal
);

    logic [W-1:0] imm_next;
    logic [W-1:0] tgt_next;
    logic         illegal_sel;

    imm_select #(.W(W)) u_sel (
        .imm_sel     (imm_sel),
        .Imm9        (Imm9),
        .Imm12       (Imm12),
        .Imm16       (Imm16),
        .Imm19       (Imm19),
        .Imm26       (Imm26),
        .mov_hw      (mov_hw),
        .pc_in       (pc_in),
        .imm_next    (imm_next),
        .tgt_next    (tgt_next),
        .illegal_sel (illegal_sel)
    );

    logic bubble;
    assign bubble = reset || flush || (!stall && !in_valid);

    always_ff @(posedge clk) begin
        if (bubble) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            imm_out   <= '0;
            br_target <= '0;
            rd_out    <= XZR;
        end else if (!stall) begin
            out_valid <= 1'b1;
            illegal   <= illegal_sel;
            imm_out   <= imm_next;
            br_target <= tgt_next;
            rd_out    <= rd_in;
        end
    end

endmodule

// File: tb/tb_id_ex_imm_stage.sv
// Self-checking bench: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_id_ex_imm_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, stall, flush, in_valid;
    logic [2:0]   imm_sel;
    logic [W-1:0] Imm9, Imm12, Imm16, Imm19, Imm26, pc_in;
    logic [1:0]   mov_hw;
    logic [4:0]   rd_in;
    logic         out_valid, illegal;
    logic [W-1:0] imm_out, br_target;
    logic [4:0]   rd_out;

    id_ex_imm_stage #(.W(W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .imm_sel(imm_sel),
        .Imm9(Imm9), .Imm12(Imm12), .Imm16(Imm16), .Imm19(Imm19), .Imm26(Imm26),
        .mov_hw(mov_hw), .pc_in(pc_in), .rd_in(rd_in),
        .out_valid(out_valid), .imm_out(imm_out), .br_target(br_target),
        .rd_out(rd_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected stage contents after each edge.
    logic        m_ok = 1'b0;
    logic        m_valid, m_ill;
    logic [63:0] m_imm, m_tgt;
    logic [4:0]  m_rd;

    function automatic logic [63:0] ref_imm(input logic [2:0] s);
        case (s)
            3'd1: return Imm9;
            3'd2: return Imm12;
            3'd3: return Imm19 * 64'd4;
            3'd4: return Imm26 * 64'd4;
            3'd5: return (Imm16 & 64'hFFFF) * (64'd1 << (16 * mov_hw));
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_tgt(input logic [2:0] s);
        if (s == 3'd3) return pc_in + Imm19 * 64'd4;
        if (s == 3'd4) return pc_in + Imm26 * 64'd4;
        return pc_in + 64'd4;
    endfunction

    always @(posedge clk) begin
        if (reset || flush || (!stall && !in_valid)) begin
            m_valid = 0; m_ill = 0; m_imm = 0; m_tgt = 0; m_rd = 5'd31;
        end else if (!stall) begin
            m_valid = 1; m_ill = (imm_sel > 3'd5);
            m_imm = ref_imm(imm_sel); m_tgt = ref_tgt(imm_sel); m_rd = rd_in;
        end
        if (reset) m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("valid", 64'(out_valid), 64'(m_valid));
            check("illegal", 64'(illegal), 64'(m_ill));
            check("imm_out", imm_out, m_imm);
            check("br_target", br_target, m_tgt);
            check("rd_out", 64'(rd_out), 64'(m_rd));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; in_valid = 0; imm_sel = 0;
        Imm9 = 0; Imm12 = 0; Imm16 = 0; Imm19 = 0; Imm26 = 0;
        mov_hw = 0; pc_in = 0; rd_in = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step(); step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd31);
        check("rst_imm", imm_out, 64'd0);
        reset = 0;

        // CB branch with negative offset
        in_valid = 1; imm_sel = 3; pc_in = 64'h1000; Imm19 = 64'hFFFF_FFFF_FFFF_FFFE; rd_in = 5'd3;
        step();
        check("cb_tgt", br_target, 64'hFF8);
        check("cb_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
        check("cb_valid", 64'(out_valid), 64'd1);

        // MOV halfword shift
        imm_sel = 5; Imm16 = 64'hFFFF_FFFF_FFFF_8001; mov_hw = 2; pc_in = 64'h2000;
        step();
        check("im_imm", imm_out, 64'h0000_8001_0000_0000);
        check("im_tgt", br_target, 64'h2004);

        // Stall holds, then flush beats stall
        imm_sel = 1; Imm9 = 64'd5; rd_in = 5'd7;
        step();
        stall = 1; Imm9 = 64'd99; imm_sel = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_imm", imm_out, 64'd5);
        end
        flush = 1;
        step();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_rd", 64'(rd_out), 64'd31);
        stall = 0; flush = 0;

        // Target wraps modulo 2^64
        imm_sel = 4; pc_in = 64'hFFFF_FFFF_FFFF_FFFC; Imm26 = 64'd1;
        step();
        check("wrap_tgt", br_target, 64'h0);

        // Reserved select flags illegal for exactly one occupancy
        imm_sel = 6;
        step();
        check("rsv_ill", 64'(illegal), 64'd1);
        check("rsv_imm", imm_out, 64'd0);
        imm_sel = 2;
        step();
        check("rsv_clear", 64'(illegal), 64'd0);

        // Reset during stall discards held contents
        stall = 1; reset = 1;
        step();
        check("rst_stall_valid", 64'(out_valid), 64'd0);
        check("rst_stall_rd", 64'(rd_out), 64'd31);
        reset = 0;
        step();
        check("post_rst_hold", 64'(out_valid), 64'd0);
        stall = 0;

        // Randomized traffic; the per-cycle compare process checks it
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 5) != 0);
            imm_sel  = 3'($urandom_range(0, 7));
            Imm9     = {$urandom, $urandom};
            Imm12    = {$urandom, $urandom};
            Imm16    = {$urandom, $urandom};
            Imm19    = {$urandom, $urandom};
            Imm26    = {$urandom, $urandom};
            mov_hw   = 2'($urandom_range(0, 3));
            pc_in    = ($urandom_range(0, 7) == 0) ? ~64'($urandom_range(0, 15)) : {$urandom, $urandom};
            rd_in    = 5'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
